// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// A BTB entry is split into metadata (this struct) and separately sized tag/target arrays.
package bp_pkg;

    typedef enum logic [1:0] {
        BRANCH = 2'd0,
        JUMP   = 2'd1,
        CALL   = 2'd2,
        RET    = 2'd3
    } cf_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic     valid;
        cf_type_e cf_type;
        logic [1:0] ctr;
    } btb_entry_t;

    // Word-aligned PC bits that select a direct-mapped entry.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'(1) << idx_w) - 64'(1));
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry, an empty pop is ignored.
module return_addr_stack #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;

    assign top   = mem[ptr - PTR_W'(1)];
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset; count qualifies every read.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit counters plus a return-address stack.
// Predicts combinationally in IF, trains from resolved EX outcomes, flags mispredicts.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned RAS_DEPTH = 4,
    parameter logic [1:0]  CTR_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  cf_type_e        upd_type,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    btb_entry_t       meta    [ENTRIES];
    logic [TAG_W-1:0] tags    [ENTRIES];
    logic [XLEN-1:0]  targets [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, btb_wr;
    logic [1:0]       ctr_next;
    logic [XLEN-1:0]  ras_top;
    logic             ras_empty;

    assign lk_idx = IDX_W'(pc_index(64'(if_pc), IDX_W));
    assign lk_tag = TAG_W'(pc_tag(64'(if_pc), IDX_W));
    assign up_idx = IDX_W'(pc_index(64'(upd_pc), IDX_W));
    assign up_tag = TAG_W'(pc_tag(64'(upd_pc), IDX_W));
    assign lk_hit = meta[lk_idx].valid && (tags[lk_idx] == lk_tag);
    assign up_hit = meta[up_idx].valid && (tags[up_idx] == up_tag);

    // Lookup reads pre-update state, so a same-cycle update becomes visible next cycle.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = if_pc + XLEN'(4);
        if (lk_hit) begin
            case (meta[lk_idx].cf_type)
                BRANCH: if (meta[lk_idx].ctr[1]) begin
                    pred_taken  = 1'b1;
                    pred_target = targets[lk_idx];
                end
                JUMP, CALL: begin
                    pred_taken  = 1'b1;
                    pred_target = targets[lk_idx];
                end
                RET: if (!ras_empty) begin
                    pred_taken  = 1'b1;
                    pred_target = ras_top;
                end
            endcase
        end
    end

    assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                       (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

    always_comb begin
        ctr_next = meta[up_idx].ctr;
        if (upd_taken) begin
            if (meta[up_idx].ctr != CTR_ST) ctr_next = meta[up_idx].ctr + 2'd1;
        end else begin
            if (meta[up_idx].ctr != CTR_SNT) ctr_next = meta[up_idx].ctr - 2'd1;
        end
    end

    // Tag/target change exactly when a taken outcome is recorded.
    assign btb_wr = upd_valid && ((upd_type != BRANCH) || upd_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                meta[i] <= '{valid: 1'b0, cf_type: BRANCH, ctr: CTR_INIT};
            end
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd_valid) begin
                if (upd_type == BRANCH) begin
                    if (up_hit) begin
                        meta[up_idx].ctr     <= ctr_next;
                        meta[up_idx].cf_type <= BRANCH;
                    end else if (upd_taken) begin
                        meta[up_idx] <= '{valid: 1'b1, cf_type: BRANCH, ctr: 2'(CTR_INIT + 2'd1)};
                    end
                end else begin
                    meta[up_idx] <= '{valid: 1'b1, cf_type: upd_type, ctr: CTR_ST};
                end
            end
            if (upd_valid && (stat_branches != '1)) stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispred != '1)) stat_mispred <= stat_mispred + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && btb_wr) begin
            tags[up_idx]    <= up_tag;
            targets[up_idx] <= upd_target;
        end
    end

    return_addr_stack #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (upd_valid && (upd_type == CALL)),
        .pop       (upd_valid && (upd_type == RET)),
        .push_data (upd_pc + XLEN'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: mispredict vector table, directed multi-cycle sequences,
// and random traffic against an associative BTB / queue-based RAS reference model.
module tb_branch_predictor;
    import bp_pkg::*;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ENTRIES   = 64;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned IDX_W     = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'h0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    cf_type_e    upd_type = BRANCH;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = 32'h0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches, stat_mispred;

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH), .CTR_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: entries keyed by index, RAS as a bounded queue.
    typedef struct {
        bit          valid;
        logic [31:0] tag;
        cf_type_e    typ;
        logic [31:0] target;
        int          ctr;
    } m_entry_t;

    m_entry_t    m_btb [ENTRIES];
    logic [31:0] m_ras [$];
    int          m_br, m_mp;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tag(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic void m_reset();
        foreach (m_btb[i]) begin
            m_btb[i].valid = 1'b0;
            m_btb[i].ctr   = 1;
        end
        m_ras.delete();
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        m_entry_t e = m_btb[m_idx(pc)];
        t  = 1'b0;
        tg = pc + 32'd4;
        if (e.valid && e.tag == m_tag(pc)) begin
            if (e.typ == BRANCH && e.ctr >= 2) begin t = 1'b1; tg = e.target; end
            if (e.typ == JUMP || e.typ == CALL) begin t = 1'b1; tg = e.target; end
            if (e.typ == RET && m_ras.size() > 0) begin t = 1'b1; tg = m_ras[$]; end
        end
    endfunction

    function automatic bit m_mispred();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && upd_target != upd_pred_target));
    endfunction

    function automatic void m_update();
        int i = m_idx(upd_pc);
        bit hit = m_btb[i].valid && m_btb[i].tag == m_tag(upd_pc);
        if (!upd_valid) return;
        m_br++;
        if (m_mispred()) m_mp++;
        if (upd_type == BRANCH) begin
            if (hit) begin
                m_btb[i].ctr = upd_taken ? ((m_btb[i].ctr == 3) ? 3 : m_btb[i].ctr + 1)
                                         : ((m_btb[i].ctr == 0) ? 0 : m_btb[i].ctr - 1);
                m_btb[i].typ = BRANCH;
                if (upd_taken) m_btb[i].target = upd_target;
            end else if (upd_taken) begin
                m_btb[i] = '{valid: 1'b1, tag: m_tag(upd_pc), typ: BRANCH, target: upd_target, ctr: 2};
            end
        end else begin
            m_btb[i] = '{valid: 1'b1, tag: m_tag(upd_pc), typ: upd_type, target: upd_target, ctr: 3};
        end
        if (upd_type == CALL) begin
            m_ras.push_back(upd_pc + 32'd4);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
        if (upd_type == RET && m_ras.size() > 0) void'(m_ras.pop_back());
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset(); else m_update();
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic drive(input cf_type_e t, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
        upd_valid = 1'b1; upd_type = t; upd_pc = pc; upd_taken = tk;
        upd_target = tg; upd_pred_taken = ptk; upd_pred_target = ptg;
    endtask

    task automatic check_lookup(input string name, input logic [31:0] pc,
                                input logic t, input logic [31:0] tg);
        if_pc = pc;
        #1;
        chk({name, "_taken"}, 32'(pred_taken), 32'(t));
        chk({name, "_target"}, pred_target, tg);
    endtask

    task automatic check_mp(input string name, input logic mp, input logic [31:0] rd);
        #1;
        chk({name, "_mispredict"}, 32'(mispredict), 32'(mp));
        chk({name, "_redirect"}, redirect_pc, rd);
    endtask

    // One training update with hand-derived mispredict expectation, then a clock edge.
    task automatic upd_step(input string name, input cf_type_e t, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tg, input logic ptk, input logic [31:0] ptg,
                            input logic mp, input logic [31:0] rd);
        drive(t, pc, tk, tg, ptk, ptg);
        check_mp(name, mp, rd);
        tick();
    endtask

    typedef struct {
        logic        valid;
        cf_type_e    typ;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        ptaken;
        logic [31:0] ptarget;
        logic        exp_mp;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic        t;
        logic [31:0] tg, base_mp;

        vecs[0] = '{1'b1, BRANCH, 32'h6000, 1'b1, 32'h6100, 1'b1, 32'h6100, 1'b0, 32'h6100};
        vecs[1] = '{1'b1, BRANCH, 32'h6004, 1'b0, 32'h6100, 1'b0, 32'h6008, 1'b0, 32'h6008};
        vecs[2] = '{1'b1, BRANCH, 32'h6008, 1'b1, 32'h6100, 1'b0, 32'h600C, 1'b1, 32'h6100};
        vecs[3] = '{1'b1, BRANCH, 32'h600C, 1'b0, 32'h6100, 1'b1, 32'h6100, 1'b1, 32'h6010};
        vecs[4] = '{1'b1, JUMP,   32'h6010, 1'b1, 32'h7000, 1'b1, 32'h7004, 1'b1, 32'h7000};
        vecs[5] = '{1'b1, CALL,   32'h6014, 1'b1, 32'h7000, 1'b1, 32'h7000, 1'b0, 32'h7000};
        vecs[6] = '{1'b1, RET,    32'h7040, 1'b1, 32'h6018, 1'b1, 32'h6018, 1'b0, 32'h6018};
        vecs[7] = '{1'b1, BRANCH, 32'h6020, 1'b0, 32'h6100, 1'b0, 32'h1234, 1'b0, 32'h6024};
        vecs[8] = '{1'b0, BRANCH, 32'h6024, 1'b1, 32'h6200, 1'b0, 32'h6028, 1'b0, 32'h6200};

        m_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_lookup("reset_lookup", 32'h100, 1'b0, 32'h104);
        chk("reset_stat_branches", stat_branches, 32'd0);
        chk("reset_stat_mispred", stat_mispred, 32'd0);
        chk("reset_mispredict", 32'(mispredict), 32'd0);

        // Mispredict compare table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].typ, vecs[i].pc, vecs[i].taken, vecs[i].target, vecs[i].ptaken, vecs[i].ptarget);
            upd_valid = vecs[i].valid;
            check_mp($sformatf("vec%0d", i), vecs[i].exp_mp, vecs[i].exp_rd);
            tick();
        end
        chk("vec_stat_branches", stat_branches, 32'd8);
        chk("vec_stat_mispred", stat_mispred, 32'd3);

        // Counter training at 0x200
        upd_step("br200_a", BRANCH, 32'h200, 1'b1, 32'h180, 1'b0, 32'h204, 1'b1, 32'h180);
        upd_step("br200_b", BRANCH, 32'h200, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0, 32'h180);
        upd_step("br200_c", BRANCH, 32'h200, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0, 32'h180);
        check_lookup("br200_sat", 32'h200, 1'b1, 32'h180);
        upd_step("br200_nt", BRANCH, 32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h204);
        check_lookup("br200_weak", 32'h200, 1'b1, 32'h180);
        // Same-cycle lookup/update: old prediction now, new one after the edge
        drive(BRANCH, 32'h200, 1'b0, 32'h180, 1'b1, 32'h180);
        check_lookup("br200_same", 32'h200, 1'b1, 32'h180);
        tick();
        check_lookup("br200_after", 32'h200, 1'b0, 32'h204);

        // Miss taken branch mispredicts; not-taken miss does not allocate
        base_mp = stat_mispred;
        upd_step("br40", BRANCH, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1, 32'h80);
        chk("br40_stat", stat_mispred, base_mp + 32'd1);
        check_lookup("br40_alloc", 32'h40, 1'b1, 32'h80);
        upd_step("br44", BRANCH, 32'h44, 1'b0, 32'h90, 1'b0, 32'h48, 1'b0, 32'h48);
        check_lookup("br44_noalloc", 32'h44, 1'b0, 32'h48);

        // RAS: single call/return, then overflow with 5 calls
        upd_step("ret_train", RET, 32'h87C, 1'b1, 32'h999C, 1'b0, 32'h880, 1'b1, 32'h999C);
        check_lookup("ret_empty", 32'h87C, 1'b0, 32'h880);
        upd_step("call300", CALL, 32'h300, 1'b1, 32'h800, 1'b0, 32'h304, 1'b1, 32'h800);
        check_lookup("ret_top", 32'h87C, 1'b1, 32'h304);
        upd_step("ret_pop", RET, 32'h87C, 1'b1, 32'h304, 1'b1, 32'h304, 1'b0, 32'h304);
        for (int i = 0; i < 5; i++) begin
            upd_step($sformatf("call%0d", i), CALL, 32'h300 + 32'(i * 16), 1'b1, 32'h800,
                     1'b1, 32'h800, 1'b0, 32'h800);
        end
        for (int i = 4; i >= 1; i--) begin
            check_lookup($sformatf("ras_pop%0d", i), 32'h87C, 1'b1, 32'h304 + 32'(i * 16));
            upd_step($sformatf("ret%0d", i), RET, 32'h87C, 1'b1, 32'h304 + 32'(i * 16),
                     1'b1, 32'h304 + 32'(i * 16), 1'b0, 32'h304 + 32'(i * 16));
        end
        check_lookup("ras_drained", 32'h87C, 1'b0, 32'h880);

        // Aliasing eviction
        upd_step("alias_a", JUMP, 32'h1000, 1'b1, 32'h2000, 1'b0, 32'h1004, 1'b1, 32'h2000);
        check_lookup("alias_a_hit", 32'h1000, 1'b1, 32'h2000);
        upd_step("alias_b", JUMP, 32'h1100, 1'b1, 32'h3000, 1'b0, 32'h1104, 1'b1, 32'h3000);
        check_lookup("alias_a_evicted", 32'h1000, 1'b0, 32'h1004);
        check_lookup("alias_b_hit", 32'h1100, 1'b1, 32'h3000);

        // Reset wins over a simultaneous update
        rst = 1'b1;
        drive(JUMP, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
        tick();
        rst = 1'b0;
        check_lookup("rst_upd_lookup", 32'h500, 1'b0, 32'h504);
        check_lookup("rst_clears_btb", 32'h1100, 1'b0, 32'h1104);
        chk("rst_upd_stat_branches", stat_branches, 32'd0);
        chk("rst_upd_stat_mispred", stat_mispred, 32'd0);

        // Random traffic over an aliasing PC pool against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc, tgt, ptg;
            logic        tk, ptk, mt;
            cf_type_e    ty;
            pc  = 32'h4000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 1) * ENTRIES * 4);
            ty  = cf_type_e'(2'($urandom_range(0, 3)));
            tk  = (ty == BRANCH) ? 1'($urandom_range(0, 1)) : 1'b1;
            tgt = 32'h8000 + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 1) == 1) m_predict(pc, ptk, ptg);
            else begin
                ptk = 1'($urandom_range(0, 1));
                ptg = 32'h8000 + 32'($urandom_range(0, 15) * 4);
            end
            drive(ty, pc, tk, tgt, ptk, ptg);
            upd_valid = ($urandom_range(0, 4) != 0);
            if_pc = 32'h4000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 1) * ENTRIES * 4);
            #1;
            m_predict(if_pc, mt, tg);
            t = m_mispred();
            chk("rnd_pred_taken", 32'(pred_taken), 32'(mt));
            chk("rnd_pred_target", pred_target, tg);
            chk("rnd_mispredict", 32'(mispredict), 32'(t));
            if (t) chk("rnd_redirect", redirect_pc, tk ? tgt : pc + 32'd4);
            tick();
        end
        chk("rnd_stat_branches", stat_branches, 32'(m_br));
        chk("rnd_stat_mispred", stat_mispred, 32'(m_mp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
